// File: rtl/rv_g_pkg.sv
// Shared types for the rv_g register-file access path.
package rv_g_pkg;
  localparam int unsigned REG_ADDR_W = 6;

  typedef logic [REG_ADDR_W-1:0] rf_addr_t;

  typedef enum logic {
    IDLE,
    HOLD
  } arb_state_e;
endpackage

// File: rtl/rv_g_regfile_arbiter_rr_pick.sv
// Rotate-priority finder: first set request at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] idx_o,
  output logic          found_o
);

  int unsigned   pos;
  logic [PW-1:0] pos_w;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = 0;
    pos_w   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos   = (32'(ptr_i) + i) % N;
      pos_w = PW'(pos);
      if (!found_o && req_i[pos_w]) begin
        found_o = 1'b1;
        idx_o   = pos_w;
      end
    end
  end

endmodule

// File: rtl/rv_g_regfile_arbiter.sv
// Round-robin arbiter sharing the register-file read/lock port among issue requesters,
// with a bounded wait before a blocked owner is rotated away from.
module rv_g_regfile_arbiter
  import rv_g_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAXLEN   = 64,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  rf_addr_t [NUM_REQ-1:0]   rd_addr_i,
  input  rf_addr_t [NUM_REQ-1:0]   rs1_addr_i,
  input  rf_addr_t [NUM_REQ-1:0]   rs2_addr_i,
  input  rf_addr_t [NUM_REQ-1:0]   rs3_addr_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [MAXLEN-1:0]        rs1_data_o,
  output logic [MAXLEN-1:0]        rs2_data_o,
  output logic [MAXLEN-1:0]        rs3_data_o,
  output logic                     rf_req_o,
  output rf_addr_t                 rf_rd_addr_o,
  output rf_addr_t                 rf_rs1_addr_o,
  output rf_addr_t                 rf_rs2_addr_o,
  output rf_addr_t                 rf_rs3_addr_o,
  input  logic                     rf_gnt_i,
  input  logic [MAXLEN-1:0]        rf_rs1_data_i,
  input  logic [MAXLEN-1:0]        rf_rs2_data_i,
  input  logic [MAXLEN-1:0]        rf_rs3_data_i,
  output logic                     rotate_o
);

  localparam int unsigned PTR_W  = $clog2(NUM_REQ);
  localparam int unsigned WCNT_W = $clog2(MAX_WAIT);
  localparam logic [PTR_W-1:0]  LAST_IDX   = PTR_W'(NUM_REQ - 1);
  localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(MAX_WAIT - 1);

  arb_state_e        st_q, st_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              rotate_q, rotate_d;

  logic [PTR_W-1:0]  pick_idx;
  logic              pick_found;
  logic [PTR_W-1:0]  cand;
  logic              cand_req;
  logic              others_active;

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] x);
    return (x == LAST_IDX) ? '0 : x + PTR_W'(1);
  endfunction

  rr_pick #(
    .N (NUM_REQ),
    .PW(PTR_W)
  ) u_pick (
    .req_i  (req_i),
    .ptr_i  (ptr_q),
    .idx_o  (pick_idx),
    .found_o(pick_found)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      st_q     <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      wcnt_q   <= '0;
      rotate_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      wcnt_q   <= wcnt_d;
      rotate_q <= rotate_d;
    end
  end

  // Request/grant qualification is gated by reset so nothing is locked while it is held.
  always_comb begin
    cand          = (st_q == HOLD) ? owner_q : pick_idx;
    cand_req      = req_i[cand] & ~arst_i;
    others_active = |(req_i & ~(NUM_REQ'(1) << owner_q));
  end

  always_comb begin
    st_d     = st_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    wcnt_d   = wcnt_q;
    rotate_d = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (pick_found && cand_req) begin
          if (rf_gnt_i) begin
            ptr_d = next_idx(cand);
          end else begin
            st_d    = HOLD;
            owner_d = cand;
            wcnt_d  = WCNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (!req_i[owner_q]) begin
          st_d   = IDLE;
          wcnt_d = '0;
        end else if (rf_gnt_i) begin
          st_d   = IDLE;
          ptr_d  = next_idx(owner_q);
          wcnt_d = '0;
        end else if (wcnt_q == WAIT_LIMIT) begin
          // Owner keeps requesting; moving ptr past it lets others in and revisits it later.
          if (others_active) begin
            st_d     = IDLE;
            ptr_d    = next_idx(owner_q);
            wcnt_d   = '0;
            rotate_d = 1'b1;
          end
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_o         = '0;
    gnt_o[cand]   = cand_req & rf_gnt_i;
    rf_req_o      = cand_req;
    rf_rd_addr_o  = cand_req ? rd_addr_i[cand]  : '0;
    rf_rs1_addr_o = cand_req ? rs1_addr_i[cand] : '0;
    rf_rs2_addr_o = cand_req ? rs2_addr_i[cand] : '0;
    rf_rs3_addr_o = cand_req ? rs3_addr_i[cand] : '0;
    rs1_data_o    = rf_rs1_data_i;
    rs2_data_o    = rf_rs2_data_i;
    rs3_data_o    = rf_rs3_data_i;
    rotate_o      = rotate_q;
  end

endmodule

// File: tb/tb_rv_g_regfile_arbiter.sv
// Directed bench for rv_g_regfile_arbiter: reset, rotation, hold, timeout, saturation, drop.
module tb_rv_g_regfile_arbiter;
  import rv_g_pkg::*;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned MAXLEN   = 64;
  localparam int unsigned MAX_WAIT = 8;

  logic                   clk_i = 1'b0;
  logic                   arst_i;
  logic [NUM_REQ-1:0]     req_i;
  rf_addr_t [NUM_REQ-1:0] rd_addr_i, rs1_addr_i, rs2_addr_i, rs3_addr_i;
  logic [NUM_REQ-1:0]     gnt_o;
  logic [MAXLEN-1:0]      rs1_data_o, rs2_data_o, rs3_data_o;
  logic                   rf_req_o;
  rf_addr_t               rf_rd_addr_o, rf_rs1_addr_o, rf_rs2_addr_o, rf_rs3_addr_o;
  logic                   rf_gnt_i;
  logic [MAXLEN-1:0]      rf_rs1_data_i, rf_rs2_data_i, rf_rs3_data_i;
  logic                   rotate_o;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk_i = ~clk_i;

  rv_g_regfile_arbiter #(
    .NUM_REQ (NUM_REQ),
    .MAXLEN  (MAXLEN),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .req_i        (req_i),
    .rd_addr_i    (rd_addr_i),
    .rs1_addr_i   (rs1_addr_i),
    .rs2_addr_i   (rs2_addr_i),
    .rs3_addr_i   (rs3_addr_i),
    .gnt_o        (gnt_o),
    .rs1_data_o   (rs1_data_o),
    .rs2_data_o   (rs2_data_o),
    .rs3_data_o   (rs3_data_o),
    .rf_req_o     (rf_req_o),
    .rf_rd_addr_o (rf_rd_addr_o),
    .rf_rs1_addr_o(rf_rs1_addr_o),
    .rf_rs2_addr_o(rf_rs2_addr_o),
    .rf_rs3_addr_o(rf_rs3_addr_o),
    .rf_gnt_i     (rf_gnt_i),
    .rf_rs1_data_i(rf_rs1_data_i),
    .rf_rs2_data_i(rf_rs2_data_i),
    .rf_rs3_data_i(rf_rs3_data_i),
    .rotate_o     (rotate_o)
  );

  // Requester k: rd=k+1, rs1=k+8, rs2=k+16, rs3=k+40.
  initial begin
    for (int k = 0; k < NUM_REQ; k++) begin
      rd_addr_i[k]  = rf_addr_t'(k + 1);
      rs1_addr_i[k] = rf_addr_t'(k + 8);
      rs2_addr_i[k] = rf_addr_t'(k + 16);
      rs3_addr_i[k] = rf_addr_t'(k + 40);
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    next_cycle();
    arst_i   = 1'b1;
    req_i    = '0;
    rf_gnt_i = 1'b0;
    next_cycle();
    arst_i = 1'b0;
  endtask

  task automatic test_reset();
    arst_i   = 1'b1;
    req_i    = 4'b1111;
    rf_gnt_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk_cnt++;
      if (gnt_o !== 4'b0000) $display("FAIL reset_gnt cyc%0d got=%b exp=0000", c, gnt_o);
      else pass_cnt++;
      chk_cnt++;
      if (rf_req_o !== 1'b0) $display("FAIL reset_rf_req cyc%0d got=%b exp=0", c, rf_req_o);
      else pass_cnt++;
      chk_cnt++;
      if (rotate_o !== 1'b0) $display("FAIL reset_rotate cyc%0d got=%b exp=0", c, rotate_o);
      else pass_cnt++;
      next_cycle();
    end
    arst_i = 1'b0;
    sample();
    chk_cnt++;
    if (gnt_o !== 4'b0001) $display("FAIL reset_first_gnt got=%b exp=0001", gnt_o);
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_rotation();
    logic [NUM_REQ-1:0] exp_g;
    logic [MAXLEN-1:0]  d;
    do_reset();
    req_i    = 4'b1111;
    rf_gnt_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = 64'hA5A5_0000_0000_0000 + 64'(i * 17);
      rf_rs1_data_i = d;
      exp_g = 4'b0001 << (i % 4);
      sample();
      chk_cnt++;
      if (gnt_o !== exp_g) $display("FAIL rot_gnt step%0d got=%b exp=%b", i, gnt_o, exp_g);
      else pass_cnt++;
      chk_cnt++;
      if (rs1_data_o !== d) $display("FAIL rot_data step%0d got=%h exp=%h", i, rs1_data_o, d);
      else pass_cnt++;
      chk_cnt++;
      if (rf_rs1_addr_o !== rf_addr_t'((i % 4) + 8))
        $display("FAIL rot_rs1_addr step%0d got=%0d exp=%0d", i, rf_rs1_addr_o, (i % 4) + 8);
      else pass_cnt++;
      next_cycle();
    end
  endtask

  task automatic test_hold();
    do_reset();
    req_i    = 4'b0101;
    rf_gnt_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk_cnt++;
      if (gnt_o !== 4'b0000) $display("FAIL hold_gnt cyc%0d got=%b exp=0000", c, gnt_o);
      else pass_cnt++;
      chk_cnt++;
      if (rf_rs1_addr_o !== 6'd8) $display("FAIL hold_rs1_addr cyc%0d got=%0d exp=8", c, rf_rs1_addr_o);
      else pass_cnt++;
      next_cycle();
    end
    rf_gnt_i = 1'b1;
    sample();
    chk_cnt++;
    if (gnt_o !== 4'b0001) $display("FAIL hold_release_gnt got=%b exp=0001", gnt_o);
    else pass_cnt++;
    next_cycle();
    req_i = 4'b0100;
    sample();
    chk_cnt++;
    if (gnt_o !== 4'b0100) $display("FAIL hold_next_gnt got=%b exp=0100", gnt_o);
    else pass_cnt++;
    next_cycle();
    req_i = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    req_i    = 4'b0011;
    rf_gnt_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      sample();
      chk_cnt++;
      if (rotate_o !== 1'b0) $display("FAIL to_no_rotate cyc%0d got=%b exp=0", c, rotate_o);
      else pass_cnt++;
      chk_cnt++;
      if (rf_rd_addr_o !== 6'd1) $display("FAIL to_owner0_rd cyc%0d got=%0d exp=1", c, rf_rd_addr_o);
      else pass_cnt++;
      next_cycle();
    end
    sample();
    chk_cnt++;
    if (rotate_o !== 1'b1) $display("FAIL to_rotate_pulse got=%b exp=1", rotate_o);
    else pass_cnt++;
    chk_cnt++;
    if (rf_rd_addr_o !== 6'd2) $display("FAIL to_owner1_rd got=%0d exp=2", rf_rd_addr_o);
    else pass_cnt++;
    chk_cnt++;
    if (rf_rs3_addr_o !== 6'd41) $display("FAIL to_owner1_rs3 got=%0d exp=41", rf_rs3_addr_o);
    else pass_cnt++;
    next_cycle();
    rf_gnt_i = 1'b1;
    sample();
    chk_cnt++;
    if (rotate_o !== 1'b0) $display("FAIL to_pulse_width got=%b exp=0", rotate_o);
    else pass_cnt++;
    chk_cnt++;
    if (gnt_o !== 4'b0010) $display("FAIL to_gnt1 got=%b exp=0010", gnt_o);
    else pass_cnt++;
    next_cycle();
    req_i = '0;
  endtask

  task automatic test_saturate();
    int bad_rot = 0;
    int bad_gnt = 0;
    do_reset();
    req_i    = 4'b1000;
    rf_gnt_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      sample();
      if (rotate_o !== 1'b0) bad_rot++;
      if (gnt_o !== 4'b0000) bad_gnt++;
      next_cycle();
    end
    chk_cnt++;
    if (bad_rot != 0) $display("FAIL sat_no_rotate got=%0d exp=0 rotate cycles", bad_rot);
    else pass_cnt++;
    chk_cnt++;
    if (bad_gnt != 0) $display("FAIL sat_no_gnt got=%0d exp=0 grant cycles", bad_gnt);
    else pass_cnt++;
    rf_gnt_i = 1'b1;
    sample();
    chk_cnt++;
    if (gnt_o !== 4'b1000) $display("FAIL sat_first_gnt got=%b exp=1000", gnt_o);
    else pass_cnt++;
    next_cycle();
    req_i = '0;
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    req_i    = 4'b0100;
    rf_gnt_i = 1'b0;
    next_cycle();
    sample();
    chk_cnt++;
    if (rf_rd_addr_o !== 6'd3) $display("FAIL rh_owner2_rd got=%0d exp=3", rf_rd_addr_o);
    else pass_cnt++;
    next_cycle();
    arst_i   = 1'b1;
    rf_gnt_i = 1'b1;
    sample();
    chk_cnt++;
    if (rf_req_o !== 1'b0) $display("FAIL rh_req_in_reset got=%b exp=0", rf_req_o);
    else pass_cnt++;
    next_cycle();
    arst_i = 1'b0;
    req_i  = 4'b0110;
    sample();
    chk_cnt++;
    if (gnt_o !== 4'b0010) $display("FAIL rh_first_gnt got=%b exp=0010", gnt_o);
    else pass_cnt++;
    next_cycle();
    req_i = '0;
  endtask

  task automatic test_drop();
    do_reset();
    req_i    = 4'b0001;
    rf_gnt_i = 1'b0;
    next_cycle();
    req_i = 4'b0000;
    sample();
    chk_cnt++;
    if (rf_req_o !== 1'b0 || rf_rd_addr_o !== 6'd0)
      $display("FAIL drop_idle got req=%b rd=%0d exp req=0 rd=0", rf_req_o, rf_rd_addr_o);
    else pass_cnt++;
    next_cycle();
    req_i    = 4'b0011;
    rf_gnt_i = 1'b1;
    sample();
    chk_cnt++;
    if (gnt_o !== 4'b0001) $display("FAIL drop_ptr_kept got=%b exp=0001", gnt_o);
    else pass_cnt++;
    next_cycle();
    req_i = '0;
  endtask

  initial begin
    arst_i        = 1'b1;
    req_i         = '0;
    rf_gnt_i      = 1'b0;
    rf_rs1_data_i = '0;
    rf_rs2_data_i = 64'h1111_2222_3333_4444;
    rf_rs3_data_i = 64'h5555_6666_7777_8888;
    test_reset();
    test_rotation();
    test_hold();
    test_timeout();
    test_saturate();
    test_reset_in_hold();
    test_drop();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
